// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Burst read engine for the RAM's registered read port. A start command
// launches a run of consecutive read addresses; returned words are parked in
// a 2-entry buffer and presented as a valid/ready stream with a last flag.
// Reads are only issued when the buffer is guaranteed to have room for the
// word when it arrives, so backpressure never drops data.
module ram_burst_reader #(
  parameter int RD_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int LEN_WIDTH     = 9
) (
  input  logic                     clkb,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  input  logic [LEN_WIDTH-1:0]     burst_len,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enb,
  output logic [ADDR_WIDTH-1:0]    ram_addrb,
  input  logic [RD_DATA_WIDTH-1:0] ram_doutb,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [RD_DATA_WIDTH-1:0] m_data,
  output logic                     m_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]     beat_left_q, beat_left_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               count_q, count_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [RD_DATA_WIDTH-1:0] fifo_q [2];
  logic [RD_DATA_WIDTH-1:0] fifo_d [2];

  logic       load;
  logic       pop;
  logic       push;
  logic [2:0] occ_after_pop;
  logic       room_for_issue;

  // Stream side and RAM address are straight decodes of the registers.
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = fifo_q[rd_ptr_q];
  assign m_last    = m_valid && (beat_left_q == LEN_WIDTH'(1));
  assign ram_addrb = addr_q;

  assign pop  = m_valid && m_ready;
  assign push = inflight_q;

  // Occupancy the buffer will have once everything already requested has
  // landed, counting the beat leaving this cycle. A new read is safe only if
  // that leaves at least one free slot for it.
  assign occ_after_pop  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign room_for_issue = (occ_after_pop < 3'd2);

  // Burst sequencing: next state, read issue and status outputs.
  always_comb begin
    state_d = state_q;
    ram_enb = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (burst_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy    = 1'b1;
        ram_enb = (issue_left_q != '0) && room_for_issue;
        if (ram_enb && (issue_left_q == LEN_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // The final beat leaving now means nothing else is buffered or in
        // flight, so completion can be flagged in the very next cycle.
        if (pop && (beat_left_q == LEN_WIDTH'(1)) && (count_q == 2'd1) && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        // Back-to-back bursts: a start seen alongside done is taken at once.
        if (start) begin
          load    = 1'b1;
          state_d = (burst_len != '0) ? READ : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and beat counters: loaded on start, stepped by issue / handshake.
  always_comb begin
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    if (load) begin
      addr_d       = start_addr;
      issue_left_d = burst_len;
      beat_left_d  = burst_len;
    end else begin
      if (ram_enb) begin
        addr_d       = addr_q + ADDR_WIDTH'(1);
        issue_left_d = issue_left_q - LEN_WIDTH'(1);
      end
      if (pop) begin
        beat_left_d = beat_left_q - LEN_WIDTH'(1);
      end
    end
  end

  // Two-entry buffer: capture returning RAM data, release on handshake.
  always_comb begin
    fifo_d     = fifo_q;
    inflight_d = ram_enb;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    count_d    = count_q + 2'(push) - 2'(pop);
    if (push) begin
      fifo_d[wr_ptr_q] = ram_doutb;
    end
  end

  // State and datapath registers; reset also drops any word still in flight.
  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q[0]    <= fifo_d[0];
      fifo_q[1]    <= fifo_d[1];
    end
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Sequential read engine that sits directly downstream of the asymmetric-width RAM's read port (port B, configured `RD_MODE="std"`). On a start command it issues a burst of consecutive read addresses on `enb`/`addrb` and turns the RAM's 1-cycle registered read data into a valid/ready stream with a last-beat flag. A 2-entry output buffer with credit-based issue absorbs backpressure without losing data and sustains one beat per cycle when the consumer never stalls.

## Interface
- `RD_DATA_WIDTH`, 32, width of the RAM read port and of `m_data`.
- `ADDR_WIDTH`, 8, width of the RAM read address (AWO of the RAM).
- `LEN_WIDTH`, 9, width of `burst_len`; a burst covers 0 to 2^LEN_WIDTH-1 beats.

- `clkb`  in  1  single clock for the block, shared with the RAM read port.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  burst request; sampled only when `busy`=0.
- `start_addr`  in  ADDR_WIDTH  first read address.
- `burst_len`  in  LEN_WIDTH  number of beats.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst completion.
- `ram_enb`  out  1  RAM read enable, to `enb`.
- `ram_addrb`  out  ADDR_WIDTH  RAM read address, to `addrb`.
- `ram_doutb`  in  RD_DATA_WIDTH  RAM read data, from `doutb`; valid the cycle after `ram_enb`=1.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  RD_DATA_WIDTH  stream data.
- `m_last`  out  1  marks the final beat of the burst.

## Operation
- FSM states:
  - IDLE -> READ on `start`=1 with `burst_len`≠0.
  - IDLE -> DONE on `start`=1 with `burst_len`=0.
  - READ -> DRAIN when the final address is issued.
  - DRAIN -> DONE when the buffer is empty, no read is in flight, and the last beat has been accepted.
  - DONE -> IDLE unconditionally.
- `busy`=1 in READ and DRAIN. `done`=1 only in DONE. `start` is ignored when `busy`=1.
- Registers:
  - `addr`: loaded with `start_addr`, incremented per issue, and wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00 at the default width).
  - `issue_left`: loaded with `burst_len`, decremented per issue.
  - `beat_left`: loaded with `burst_len`, decremented per output handshake.
- `ram_addrb` = `addr`, combinational from the register.
- Issue rule, in READ: `ram_enb` = (`issue_left`≠0) && (`count` + `inflight` − (`m_valid`&&`m_ready`) < 2).
  - `count` = buffer occupancy, 0..2.
  - `inflight` = `ram_enb` registered by one cycle.
  - `ram_enb`=0 in all other states.
- Capture: when `inflight`=1, `ram_doutb` is written into the 2-entry FIFO. A capture and a pop in the same cycle leave `count` unchanged. The issue rule guarantees the FIFO never overflows.
- Output:
  - `m_valid` = (`count`≠0); `m_data` = FIFO head.
  - `m_last` = `m_valid` && (`beat_left`==1).
  - A handshake occurs when `m_valid`&&`m_ready`.
  - `m_data`/`m_last` hold stable while `m_valid`&&!`m_ready`.
- Reset mid-burst: the FSM returns to IDLE, all counters and the FIFO clear, and any in-flight RAM data is discarded (the `inflight` flag is cleared).

## Timing
- Reset values: `busy`=0, `done`=0, `ram_enb`=0, `ram_addrb`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
- `start` is sampled at edge E0.
  - First `ram_enb` is in cycle 1.
  - Data is on `ram_doutb` in cycle 2 and captured at the end of cycle 2.
  - First `m_valid` is in cycle 3, so latency is 3 cycles.
- With `m_ready` held at 1: one issue and one beat per cycle. A burst of N takes N+2 cycles from first `ram_enb` to last beat, and `done` comes 1 cycle after the last handshake.
- `done` pulses in the cycle after the last handshake, with `busy`=0 in that same cycle. A new `start` is accepted in the `done` cycle.
- For `burst_len`=0: `done` in cycle 1, no `ram_enb`, no `m_valid`.
- With `m_ready`=0 from the start: exactly 2 reads are issued (cycles 1 and 2), then `ram_enb` stays 0 until a pop occurs.

## Test plan
- RAM preloaded with word[k]=k. start_addr=0x10, len=4, m_ready=1 -> `ram_addrb` 0x10..0x13 in cycles 1-4; `m_data` 0x10..0x13 in cycles 3-6; `m_last` only in cycle 6; `done` in cycle 7.
- Same burst with m_ready toggling 1,0,1,0 -> beats 0x10..0x13 in order with no loss or duplicates; `count`≤2 throughout; data holds stable during stalls.
- m_ready=0 for 10 cycles, len=8 -> exactly two `ram_enb` pulses; after release, 8 beats in order and `m_last` on beat 8.
- start_addr=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 and data matching those words.
- len=0 -> `done` in cycle 1, no beats. A `start` during a burst is ignored and the original burst completes unchanged.
- `rst_n`=0 during the third beat of len=8 -> next cycle `m_valid`=0, `busy`=0; a following burst len=2 from 0x20 outputs exactly 0x20, 0x21.
